// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle control FSM for an RV32I subset
// (add, sub, and, or, lw, sw, beq). Sequences fetch, decode, execute,
// memory access and write-back, and drives every datapath enable/select.
// Outputs are Moore-decoded from the state and the registered instruction;
// the only exception is pc_write in EX_BEQ, which follows the ALU zero flag.
// Optional feature macro: RETIRE_COUNT_EN adds a saturating retired-instruction
// counter on output retired_count.
module multicycle_control #(
  parameter int DMEM_WAIT = 1,
  parameter int CNT_W     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic        imem_en,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic [1:0]  imm_sel,
  output logic        alu_src_b,
  output logic [3:0]  alu_ctrl,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        busy,
  output logic        halted,
  output logic        error
`ifdef RETIRE_COUNT_EN
  ,
  output logic [CNT_W-1:0] retired_count
`endif
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_FWAIT   = 4'd2,
    S_DECODE  = 4'd3,
    S_EX_R    = 4'd4,
    S_WB_R    = 4'd5,
    S_EX_ADDR = 4'd6,
    S_MEM_RD  = 4'd7,
    S_WB_LD   = 4'd8,
    S_MEM_WR  = 4'd9,
    S_EX_BEQ  = 4'd10,
    S_HALT    = 4'd11,
    S_ERROR   = 4'd12
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  // Last wait-counter value spent in MEM_RD; the counter never has to pass 3.
  localparam logic [1:0] WAIT_LAST = 2'(DMEM_WAIT);

  state_e     state_q, state_d;
  logic [1:0] wait_cnt_q, wait_cnt_d;

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [6:0] funct7_s;
  logic       r_ok_s;
  logic [3:0] r_alu_s;
  logic       is_r_s;
  logic       is_lw_s;
  logic       is_sw_s;
  logic       is_beq_s;
  logic       is_halt_s;

  // Register-number fields are datapath business; the controller ignores them.
  logic unused_fields_s;
  assign unused_fields_s = ^{instr[24:15], instr[11:7]};

  // Instruction classification from the registered instruction word.
  always_comb begin
    opcode_s = instr[6:0];
    funct3_s = instr[14:12];
    funct7_s = instr[31:25];
    r_ok_s   = 1'b0;
    r_alu_s  = ALU_ADD;
    case ({funct7_s, funct3_s})
      10'b0000000_000: begin r_ok_s = 1'b1; r_alu_s = ALU_ADD; end
      10'b0100000_000: begin r_ok_s = 1'b1; r_alu_s = ALU_SUB; end
      10'b0000000_111: begin r_ok_s = 1'b1; r_alu_s = ALU_AND; end
      10'b0000000_110: begin r_ok_s = 1'b1; r_alu_s = ALU_OR;  end
      default:         begin r_ok_s = 1'b0; r_alu_s = ALU_ADD; end
    endcase
    is_halt_s = (instr == 32'h0000_0000);
    is_r_s    = (opcode_s == OP_R) && r_ok_s;
    is_lw_s   = (opcode_s == OP_LOAD)   && (funct3_s == 3'b010);
    is_sw_s   = (opcode_s == OP_STORE)  && (funct3_s == 3'b010);
    is_beq_s  = (opcode_s == OP_BRANCH) && (funct3_s == 3'b000);
  end

  // Next-state logic and the MEM_RD wait counter (zero outside MEM_RD,
  // so it is already cleared on entry).
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH:  state_d = S_FWAIT;
      S_FWAIT:  state_d = S_DECODE;
      S_DECODE: begin
        if (is_halt_s) begin
          state_d = S_HALT;
        end else if (is_r_s) begin
          state_d = S_EX_R;
        end else if (is_lw_s || is_sw_s) begin
          state_d = S_EX_ADDR;
        end else if (is_beq_s) begin
          state_d = S_EX_BEQ;
        end else begin
          state_d = S_ERROR;
        end
      end
      S_EX_R:   state_d = S_WB_R;
      S_WB_R:   state_d = S_FETCH;
      S_EX_ADDR: begin
        if (is_lw_s) begin
          state_d = S_MEM_RD;
        end else if (is_sw_s) begin
          state_d = S_MEM_WR;
        end else begin
          state_d = S_ERROR;
        end
      end
      S_MEM_RD: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_WB_LD;
        end else begin
          state_d    = S_MEM_RD;
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      S_WB_LD:  state_d = S_FETCH;
      S_MEM_WR: state_d = S_FETCH;
      S_EX_BEQ: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_ERROR;
    endcase
  end

  // Moore output decode; pc_write in EX_BEQ is the one combinational path from zero.
  always_comb begin
    imem_en    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    imm_sel    = IMM_I;
    alu_src_b  = 1'b0;
    alu_ctrl   = ALU_ADD;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    busy       = 1'b1;
    halted     = 1'b0;
    error      = 1'b0;
    case (state_q)
      S_IDLE:   busy = 1'b0;
      S_FETCH:  imem_en = 1'b1;
      S_FWAIT: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        pc_src   = 1'b0;
      end
      S_DECODE: imm_sel = IMM_B;
      S_EX_R: begin
        alu_src_b = 1'b0;
        alu_ctrl  = r_alu_s;
      end
      S_WB_R: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b0;
        alu_ctrl   = r_alu_s;
      end
      S_EX_ADDR: begin
        alu_src_b = 1'b1;
        alu_ctrl  = ALU_ADD;
        if (is_sw_s) begin
          imm_sel = IMM_S;
        end else begin
          imm_sel = IMM_I;
        end
      end
      S_MEM_RD: dmem_read = 1'b1;
      S_WB_LD: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        dmem_write = 1'b1;
        imm_sel    = IMM_S;
        alu_src_b  = 1'b1;
      end
      S_EX_BEQ: begin
        alu_src_b = 1'b0;
        alu_ctrl  = ALU_SUB;
        imm_sel   = IMM_B;
        pc_write  = zero;
        pc_src    = 1'b1;
      end
      S_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      S_ERROR: begin
        busy  = 1'b0;
        error = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // State and wait-counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef RETIRE_COUNT_EN
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire_s;

  // An instruction retires when a completing state hands back to FETCH.
  always_comb begin
    retire_s  = 1'b0;
    retired_d = retired_q;
    if ((state_d == S_FETCH) &&
        ((state_q == S_WB_R) || (state_q == S_WB_LD) ||
         (state_q == S_MEM_WR) || (state_q == S_EX_BEQ))) begin
      retire_s = 1'b1;
    end else begin
      retire_s = 1'b0;
    end
    if (retire_s && (retired_q != {CNT_W{1'b1}})) begin
      retired_d = retired_q + CNT_W'(1);
    end else begin
      retired_d = retired_q;
    end
  end

  // Saturating retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= {CNT_W{1'b0}};
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired_count = retired_q;
`else
  // Without the retire counter CNT_W sizes nothing; keep it referenced.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (DMEM_WAIT = 1).
// Outputs are packed into one vector and compared against hand-written
// per-state expectations; a mask hides selects the design leaves free.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] instr;
  logic        zero;
  logic        imem_en, ir_write, pc_write, pc_src, alu_src_b;
  logic [1:0]  imm_sel;
  logic [3:0]  alu_ctrl;
  logic        dmem_read, dmem_write, reg_write, mem_to_reg, busy, halted, error;
`ifdef RETIRE_COUNT_EN
  logic [31:0] retired_count;
`endif

  int checks = 0;
  int errors = 0;

  multicycle_control #(.DMEM_WAIT(1), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .zero(zero),
`ifdef RETIRE_COUNT_EN
    .retired_count(retired_count),
`endif
    .imem_en(imem_en), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .imm_sel(imm_sel), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .busy(busy), .halted(halted), .error(error)
  );

  always #5 clk = ~clk;

  // {imem,irw,pcw,pcs} {imm_sel} {alu_src_b} {alu_ctrl} {dr,dw,rw,m2r} {busy,halted,error}
  logic [17:0] obs_s;
  assign obs_s = {imem_en, ir_write, pc_write, pc_src, imm_sel, alu_src_b, alu_ctrl,
                  dmem_read, dmem_write, reg_write, mem_to_reg, busy, halted, error};

  localparam logic [17:0] B_PCS = 18'h04000;
  localparam logic [17:0] B_IMM = 18'h03000;
  localparam logic [17:0] B_ASB = 18'h00800;
  localparam logic [17:0] B_ALU = 18'h00780;
  localparam logic [17:0] B_M2R = 18'h00008;
  localparam logic [17:0] M_ALL = 18'h3FFFF;
  localparam logic [17:0] M_S   = 18'h38077;  // strobes + status only

  localparam logic [17:0] V_IDLE   = {4'b0000, 2'b00, 1'b0, 4'b0010, 4'b0000, 3'b000};
  localparam logic [17:0] V_FETCH  = {4'b1000, 2'b00, 1'b0, 4'b0010, 4'b0000, 3'b100};
  localparam logic [17:0] V_FWAIT  = {4'b0110, 2'b00, 1'b0, 4'b0010, 4'b0000, 3'b100};
  localparam logic [17:0] V_DEC    = {4'b0000, 2'b10, 1'b0, 4'b0010, 4'b0000, 3'b100};
  localparam logic [17:0] V_EXA_LD = {4'b0000, 2'b00, 1'b1, 4'b0010, 4'b0000, 3'b100};
  localparam logic [17:0] V_EXA_ST = {4'b0000, 2'b01, 1'b1, 4'b0010, 4'b0000, 3'b100};
  localparam logic [17:0] V_MRD    = {4'b0000, 2'b00, 1'b0, 4'b0010, 4'b1000, 3'b100};
  localparam logic [17:0] V_WBLD   = {4'b0000, 2'b00, 1'b0, 4'b0010, 4'b0011, 3'b100};
  localparam logic [17:0] V_MWR    = {4'b0000, 2'b01, 1'b1, 4'b0010, 4'b0100, 3'b100};
  localparam logic [17:0] V_BEQ_T  = {4'b0011, 2'b10, 1'b0, 4'b0110, 4'b0000, 3'b100};
  localparam logic [17:0] V_BEQ_N  = {4'b0001, 2'b10, 1'b0, 4'b0110, 4'b0000, 3'b100};
  localparam logic [17:0] V_HALT   = {4'b0000, 2'b00, 1'b0, 4'b0010, 4'b0000, 3'b010};
  localparam logic [17:0] V_ERR    = {4'b0000, 2'b00, 1'b0, 4'b0010, 4'b0000, 3'b001};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [17:0] exp, input logic [17:0] mask);
    checks++;
    assert ((obs_s & mask) === (exp & mask)) else begin
      errors++;
      $error("FAIL %s observed=%05h expected=%05h mask=%05h", tag, obs_s, exp, mask);
    end
  endtask

  // FETCH, FWAIT, DECODE for one instruction; entered while in FETCH.
  task automatic front(input string tag, input logic [31:0] iw);
    instr = iw;
    #1;
    chk({tag, "/fetch"}, V_FETCH, M_S);          tick;
    chk({tag, "/fwait"}, V_FWAIT, M_S | B_PCS);  tick;
    chk({tag, "/decode"}, V_DEC, M_S | B_IMM);   tick;
  endtask

  task automatic run_r(input string tag, input logic [31:0] iw, input logic [3:0] alu);
    front(tag, iw);
    chk({tag, "/ex"}, {4'b0000, 2'b00, 1'b0, alu, 4'b0000, 3'b100}, M_S | B_ASB | B_ALU); tick;
    chk({tag, "/wb"}, {4'b0000, 2'b00, 1'b0, alu, 4'b0010, 3'b100}, M_S | B_ALU | B_M2R); tick;
  endtask

  task automatic run_lw(input string tag, input logic [31:0] iw);
    front(tag, iw);
    chk({tag, "/exaddr"}, V_EXA_LD, M_S | B_ASB | B_ALU | B_IMM); tick;
    chk({tag, "/memrd0"}, V_MRD, M_S);                            tick;
    chk({tag, "/memrd1"}, V_MRD, M_S);                            tick;
    chk({tag, "/wbld"}, V_WBLD, M_S | B_M2R);                     tick;
  endtask

  task automatic run_beq(input string tag, input logic [31:0] iw, input logic zb);
    front(tag, iw);
    zero = zb;
    #1;
    chk({tag, "/exbeq"}, zb ? V_BEQ_T : V_BEQ_N, M_S | B_PCS | B_IMM | B_ASB | B_ALU);
    tick;
    zero = 1'b0;
  endtask

  task automatic run_sw(input string tag, input logic [31:0] iw);
    front(tag, iw);
    chk({tag, "/exaddr"}, V_EXA_ST, M_S | B_ASB | B_ALU | B_IMM); tick;
    chk({tag, "/memwr"}, V_MWR, M_S | B_IMM | B_ASB);             tick;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; instr = 32'h0; zero = 1'b0;
    tick; tick;
    chk("reset_idle", V_IDLE, M_ALL);
`ifdef RETIRE_COUNT_EN
    checks++;
    assert (retired_count === 32'd0) else begin
      errors++; $error("FAIL retire_reset observed=%0d expected=0", retired_count);
    end
`endif
    reset = 1'b0;
    tick;
    chk("idle_wait", V_IDLE, M_ALL);

    // Program: add, sub, and, or, lw, beq taken, beq not taken, sw, halt.
    instr = 32'h0010_0133; start = 1'b1;
    tick;
    start = 1'b0;
    run_r("add", 32'h0010_0133, 4'b0010);
    run_r("sub", 32'h4020_8133, 4'b0110);
    run_r("and", 32'h0020_F133, 4'b0000);
    run_r("or",  32'h0020_E133, 4'b0001);
    run_lw("lw", 32'h000A_2183);
    run_beq("beq_t", 32'h0020_8663, 1'b1);
    run_beq("beq_n", 32'h0020_8663, 1'b0);
    run_sw("sw", 32'h00A8_2023);
    front("halt", 32'h0000_0000);
    chk("halt_enter", V_HALT, M_S);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("halt_start_ignored", V_HALT, M_S);
    tick;
    chk("halt_hold", V_HALT, M_S);
`ifdef RETIRE_COUNT_EN
    checks++;
    assert (retired_count === 32'd8) else begin
      errors++; $error("FAIL retire_count observed=%0d expected=8", retired_count);
    end
`endif

    // Unsupported encoding lands in ERROR and stays there.
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("reset2_idle", V_IDLE, M_ALL);
    instr = 32'h0000_007F; start = 1'b1;
    tick;
    start = 1'b0;
    front("bad", 32'h0000_007F);
    chk("error_enter", V_ERR, M_S);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("error_hold", V_ERR, M_S);

    // Reset arriving in MEM_RD drops every strobe in the next cycle.
    reset = 1'b1;
    tick;
    reset = 1'b0;
    instr = 32'h000A_2183; start = 1'b1;
    tick;
    start = 1'b0;
    front("lw_rst", 32'h000A_2183);
    chk("lw_rst/exaddr", V_EXA_LD, M_S | B_ASB | B_ALU | B_IMM); tick;
    chk("lw_rst/memrd", V_MRD, M_S);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("midreset_idle", V_IDLE, M_ALL);
    tick;
    chk("midreset_stay", V_IDLE, M_ALL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM for the RV32I-subset datapath: add, sub, and, or, lw, sw, beq.
- Sequences fetch from the synchronous instruction memory (one-cycle registered read) and then decode, execute, memory access and write-back.
- Drives every datapath enable and mux select.
- Detects end of program (all-zero word) and unsupported encodings.

Parameters:
- DMEM_WAIT, 1, number of wait cycles between a data-memory read request and data valid (0..3).
- CNT_W, 32, width of the retired-instruction counter (optional feature only).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; instruction memory is loaded while high
- start  in  1  one-cycle pulse; leaves IDLE and begins fetching at current PC
- instr  in  32  instruction register contents (valid from DECODE onward)
- zero  in  1  ALU zero flag
- imem_en  out  1  instruction memory read enable (registered read, data next cycle)
- ir_write  out  1  latch instr into IR and save old PC
- pc_write  out  1  PC update enable
- pc_src  out  1  0 = PC+4, 1 = saved PC + B-immediate
- imm_sel  out  2  00 I-type, 01 S-type, 10 B-type
- alu_src_b  out  1  0 = rs2, 1 = immediate
- alu_ctrl  out  4  0010 add, 0110 sub, 0000 and, 0001 or
- dmem_read  out  1  data-memory read strobe
- dmem_write  out  1  data-memory write strobe
- reg_write  out  1  register-file write enable
- mem_to_reg  out  1  0 = ALU result, 1 = memory data
- busy  out  1  high in any state other than IDLE, HALT, ERROR
- halted  out  1  high in HALT
- error  out  1  high in ERROR

Behaviour:
- Reset (synchronous, active-high): state IDLE. All outputs are 0 in the cycle after reset is sampled high, except alu_ctrl = 0010. This holds also when reset hits mid-instruction. No write strobe may be asserted in that cycle.
- All outputs are Moore, decoded from state plus the registered instr. Only exception: pc_write in EX_BEQ, which depends on zero.
- IDLE: waits for start = 1 and goes to FETCH. start is ignored in every other state.
- FETCH: imem_en = 1; next state FWAIT.
- FWAIT: ir_write = 1, pc_write = 1, pc_src = 0 (PC <= PC+4); next state DECODE.
- DECODE: classify instr.
  - instr == 32'h0 -> HALT.
  - opcode 0110011 with (funct7, funct3) = (0000000, 000) add, (0100000, 000) sub, (0000000, 111) and, (0000000, 110) or -> EX_R.
  - opcode 0000011 with funct3 010 -> EX_ADDR (load).
  - opcode 0100011 with funct3 010 -> EX_ADDR (store).
  - opcode 1100011 with funct3 000 -> EX_BEQ.
  - Anything else -> ERROR.
  - In DECODE, imm_sel = 10 so the datapath can precompute the branch target.
- EX_R: alu_src_b = 0; alu_ctrl per funct; next state WB_R.
- WB_R: reg_write = 1, mem_to_reg = 0, alu_ctrl held; next state FETCH.
- EX_ADDR: alu_src_b = 1, alu_ctrl = 0010, imm_sel = 00 for load or 01 for store. Next state MEM_RD for load, MEM_WR for store.
- MEM_RD: dmem_read = 1, held for 1 + DMEM_WAIT cycles via an internal wait counter; next state WB_LD.
- WB_LD: reg_write = 1, mem_to_reg = 1; next state FETCH.
- MEM_WR: dmem_write = 1 for exactly one cycle, imm_sel = 01, alu_src_b = 1; next state FETCH.
- EX_BEQ: alu_src_b = 0, alu_ctrl = 0110, imm_sel = 10. pc_write = zero, pc_src = 1. Next state FETCH regardless of outcome.
- HALT and ERROR: absorbing; only reset exits. All strobes 0.
- Cycle counts (start-of-FETCH to next FETCH):
  - R-type: 5
  - lw: 6 + DMEM_WAIT
  - sw: 5
  - beq: 4
- Wait counter: 2 bits; cleared on entering MEM_RD; must not wrap for DMEM_WAIT up to 3.

Optional Feature:
- Macro: RETIRE_COUNT_EN.
- Defined: adds output retired_count [CNT_W-1:0].
  - Cleared on reset.
  - Increments by 1 on each transition into FETCH from WB_R, WB_LD, MEM_WR or EX_BEQ.
  - Saturates at all-ones; not incremented on HALT or ERROR entry.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, start pulse, instr = 0x00100133 (add x2,x0,x1) -> states FETCH, FWAIT, DECODE, EX_R, WB_R; reg_write = 1 in exactly cycle 5 after start; alu_ctrl = 0010.
- instr = 0x000A2183 (lw x3,0(x20)), DMEM_WAIT = 1 -> dmem_read high 2 cycles, then reg_write = 1 with mem_to_reg = 1; next FETCH 7 cycles after first FETCH.
- instr = 0x00208663 (beq x1,x2): zero = 1 -> pc_write = 1 and pc_src = 1 in EX_BEQ; repeat with zero = 0 -> pc_write = 0 in EX_BEQ.
- instr = 0x00A82023 (sw) -> dmem_write pulses exactly one cycle with imm_sel = 01. Then instr = 0x00000000 -> halted = 1, busy = 0; later start pulses ignored.
- instr = 0x0000007F (unsupported) -> error = 1 and no write strobes. Separately, reset asserted during MEM_RD -> all strobes 0 next cycle, state IDLE.
- With RETIRE_COUNT_EN: run add, sub, lw, sw, beq, then halt word -> retired_count = 5 and holds.
